// File: rtl/jtframe_info_scan_pkg.sv
// Shared constants for the debug-info scanner: entry count, the select
// value for each snapshot entry, and the scan FSM state type.
package jtframe_info_scan_pkg;

  localparam int unsigned N_ENTRIES = 19;

  // Entries 0-15 cover the input page; then status, ioctl flags and hps_index.
  localparam logic [7:0] SEL_TABLE [N_ENTRIES] = '{
    8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
    8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F,
    8'h00, 8'h80, 8'hC0
  };

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WAIT,
    CAP,
    DONE
  } state_t;

endpackage

// File: rtl/jtframe_info_scan_if.sv
// Bus bundle between the info scanner, the info mux and the snapshot readers.
interface jtframe_info_scan_if;
  import jtframe_info_scan_pkg::*;

  logic                 enable;
  logic                 freeze;
  logic [7:0]           manual_sel;
  logic [7:0]           sel;
  logic [7:0]           info_in;
  logic [4:0]           rd_addr;
  logic [7:0]           rd_data;
  logic                 busy;
  logic                 scan_done;
  logic [N_ENTRIES-1:0] chg;
  logic                 chg_clr;

  modport master (
    input  enable, freeze, manual_sel, info_in, rd_addr, chg_clr,
    output sel, rd_data, busy, scan_done, chg
  );

  modport slave (
    output enable, freeze, manual_sel, info_in, rd_addr, chg_clr,
    input  sel, rd_data, busy, scan_done, chg
  );
endinterface

// File: rtl/jtframe_info_scan_mem.sv
// 19x8 snapshot register file with a registered read port.
// Optional change flags are built only with JTFRAME_INFO_SCAN_CHG_EN defined.
module jtframe_info_scan_mem
  import jtframe_info_scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [7:0]           wdata,
  input  logic [4:0]           raddr,
  output logic [7:0]           rdata,
  input  logic                 chg_clr,
  output logic [N_ENTRIES-1:0] chg
);

  logic [7:0] mem [N_ENTRIES];

  // Reading the entry being written returns the pre-write byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= (raddr < 5'(N_ENTRIES)) ? mem[raddr] : '0;
    end
  end

`ifdef JTFRAME_INFO_SCAN_CHG_EN
  // The set is issued after the clear so a same-cycle capture wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg <= '0;
    end else begin
      if (chg_clr) chg <= '0;
      if (we && wdata != mem[waddr]) chg[waddr] <= 1'b1;
    end
  end
`else
  logic unused_chg_clr;
  assign unused_chg_clr = chg_clr;
  assign chg = '0;
`endif

endmodule

// File: rtl/jtframe_info_scan.sv
// Periodic debug-info mux scanner: walks SEL_TABLE, captures each byte into
// the snapshot file. Optional change flags: JTFRAME_INFO_SCAN_CHG_EN.
module jtframe_info_scan
  import jtframe_info_scan_pkg::*;
#(
  parameter logic [15:0] PERIOD = 16'd4096,
  parameter int unsigned LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_info_scan_if.master bus
);

  state_t      st, st_nx;
  logic [4:0]  idx, idx_nx;
  logic [2:0]  wcnt, wcnt_nx;
  logic [15:0] timer, timer_nx;
  logic        run_ok, expire;

  assign run_ok = bus.enable & ~bus.freeze;
  assign expire = (PERIOD == 16'd0) || (timer == PERIOD - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      idx   <= '0;
      wcnt  <= '0;
      timer <= '0;
    end else begin
      st    <= st_nx;
      idx   <= idx_nx;
      wcnt  <= wcnt_nx;
      timer <= timer_nx;
    end
  end

  always_comb begin
    st_nx    = st;
    idx_nx   = idx;
    wcnt_nx  = wcnt;
    timer_nx = '0;
    case (st)
      IDLE: begin
        idx_nx = '0;
        if (run_ok) begin
          if (expire) st_nx = SEL;
          else        timer_nx = timer + 16'd1;
        end
      end
      SEL: begin
        wcnt_nx = '0;
        st_nx   = WAIT;
      end
      WAIT: begin
        if (wcnt == 3'(LAT - 1)) st_nx = CAP;
        else                     wcnt_nx = wcnt + 3'd1;
      end
      CAP: begin
        if (idx == 5'(N_ENTRIES - 1)) begin
          st_nx = DONE;
        end else begin
          idx_nx = idx + 5'd1;
          st_nx  = SEL;
        end
      end
      DONE: begin
        idx_nx = '0;
        st_nx  = IDLE;
      end
      default: begin
        idx_nx = '0;
        st_nx  = IDLE;
      end
    endcase
    // Abort overrides sequencing; the capture of the current CAP still lands.
    if (st != IDLE && !bus.enable) begin
      st_nx  = IDLE;
      idx_nx = '0;
    end
  end

  always_comb begin
    if (rst)                         bus.sel = '0;
    else if (st == IDLE || st == DONE) bus.sel = bus.manual_sel;
    else                             bus.sel = SEL_TABLE[idx];
  end

  assign bus.busy      = (st != IDLE);
  assign bus.scan_done = (st == DONE);

  jtframe_info_scan_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (st == CAP),
    .waddr   (idx),
    .wdata   (bus.info_in),
    .raddr   (bus.rd_addr),
    .rdata   (bus.rd_data),
    .chg_clr (bus.chg_clr),
    .chg     (bus.chg)
  );

endmodule
